// File: rtl/cordic_vector_if.sv
// cordic_vector_if: request/result bundle for the vectoring CORDIC
// master drives the request, slave returns magnitude and angle
interface cordic_vector_if;
    logic        start;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic        busy;
    logic        done;
    logic [31:0] mag_out;
    logic [31:0] angle_out;

    modport master (
        output start, x_in, y_in,
        input  busy, done, mag_out, angle_out
    );

    modport slave (
        input  start, x_in, y_in,
        output busy, done, mag_out, angle_out
    );
endinterface

// File: rtl/cordic_vector.sv
// cordic_vector: iterative vectoring-mode CORDIC, one micro-rotation per clock
// (x, y) Q2.30 -> gain-compensated magnitude Q2.30 and atan2 angle Q3.29
module cordic_vector (
    input logic            clock,
    input logic            reset_n,
    cordic_vector_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ITER, SCALE} state_t;

    localparam logic [31:0] HALF_PI = 32'h6487ED51;
    localparam logic [31:0] K_GAIN  = 32'h26DD3B6A;
    localparam logic [31:0] ATAN [32] = '{
        32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
        32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
        32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
        32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
        32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
        32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
        32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000007,
        32'h00000003, 32'h00000001, 32'h00000000, 32'h00000000
    };

    state_t             state;
    state_t             state_nx;
    logic signed [33:0] x;
    logic signed [33:0] y;
    logic signed [33:0] z;
    logic        [4:0]  count;
    logic signed [33:0] xi;
    logic signed [33:0] yi;
    logic signed [33:0] xs;
    logic signed [33:0] ys;
    logic signed [33:0] beta;
    logic        [65:0] prod;
    logic               unused_bits;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start) state_nx = ITER;
            ITER:    if (count == 5'd31) state_nx = SCALE;
            SCALE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    assign xi   = {{2{bus.x_in[31]}}, bus.x_in};
    assign yi   = {{2{bus.y_in[31]}}, bus.y_in};
    assign xs   = x >>> count;
    assign ys   = y >>> count;
    assign beta = {2'b00, ATAN[count]};

    // x is never negative when this product is used, so unsigned is exact
    assign prod        = {32'd0, x} * {34'd0, K_GAIN};
    assign unused_bits = ^{prod[65:62], prod[29:0], z[33], z[0]};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x             <= '0;
            y             <= '0;
            z             <= '0;
            count         <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.mag_out   <= '0;
            bus.angle_out <= '0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.busy <= 1'b1;
                        count    <= '0;
                        if (!bus.x_in[31]) begin
                            x <= xi;
                            y <= yi;
                            z <= '0;
                        end else if (!bus.y_in[31]) begin
                            x <= yi;
                            y <= -xi;
                            z <= {2'b00, HALF_PI};
                        end else begin
                            x <= -yi;
                            y <= xi;
                            z <= -{2'b00, HALF_PI};
                        end
                    end
                end
                ITER: begin
                    if (!y[33]) begin
                        x <= x + ys;
                        y <= y - xs;
                        z <= z + beta;
                    end else begin
                        x <= x - ys;
                        y <= y + xs;
                        z <= z - beta;
                    end
                    count <= count + 5'd1;
                end
                SCALE: begin
                    bus.mag_out   <= x[33] ? 32'd0 : prod[61:30];
                    bus.angle_out <= z[32:1];
                    bus.done      <= 1'b1;
                    bus.busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: directed and random checks of cordic_vector
// against a real-valued sqrt/atan2 reference
module tb_cordic_vector;
    logic clock;
    logic reset_n;
    int   checks = 0;
    int   passed = 0;

    cordic_vector_if bus ();

    cordic_vector dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam real Q30    = 1073741824.0;
    localparam real Q29    = 536870912.0;
    localparam real TWO_PI = 6.283185307179586;

    function automatic real qv(input logic [31:0] v);
        return real'(longint'($signed(v))) / Q30;
    endfunction

    function automatic real ref_mag(input logic [31:0] xv, input logic [31:0] yv);
        return $sqrt(qv(xv) * qv(xv) + qv(yv) * qv(yv)) * Q30;
    endfunction

    function automatic real ref_ang(input logic [31:0] xv, input logic [31:0] yv);
        return $atan2(qv(yv), qv(xv)) * Q29;
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic [31:0] obs,
                            input real want, input bit is_ang);
        real o;
        real d;
        o = is_ang ? real'(longint'($signed(obs))) : real'(longint'(obs));
        d = o - want;
        if (is_ang) begin
            if (d > TWO_PI * Q29 / 2.0) d -= TWO_PI * Q29;
            else if (d < -TWO_PI * Q29 / 2.0) d += TWO_PI * Q29;
        end
        checks++;
        assert ((d <= 16.0 && d >= -16.0) === 1'b1) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h want %0.1f", tag, obs, want);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [31:0] xv,
                           input logic [31:0] yv);
        chk_near({tag, "_mag"}, bus.mag_out, ref_mag(xv, yv), 1'b0);
        chk_near({tag, "_ang"}, bus.angle_out, ref_ang(xv, yv), 1'b1);
    endtask

    // drive one request and wait (bounded) for done; checks latency
    task automatic run_conv(input string tag, input logic [31:0] xv,
                            input logic [31:0] yv);
        int  n;
        bit  got;
        bus.x_in  = xv;
        bus.y_in  = yv;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        chk_eq({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clock);
            #1;
            n++;
            if (bus.done) got = 1'b1;
        end
        chk_eq({tag, "_lat"}, n, 32'd33);
        chk_eq({tag, "_busy_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic [31:0] vx [4];
        logic [31:0] vy [4];
        logic [31:0] pm;
        logic [31:0] pa;
        logic [31:0] rx;
        logic [31:0] ry;
        int          ndone;
        int          at [3];
        int          unstable;
        int          bad;

        bus.start = 1'b0;
        bus.x_in  = '0;
        bus.y_in  = '0;
        reset_n   = 1'b0;

        // reset held with start high
        bus.start = 1'b1;
        bus.x_in  = 32'h40000000;
        bad = 0;
        repeat (3) begin
            @(posedge clock);
            #1;
            if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                bus.mag_out !== 32'd0 || bus.angle_out !== 32'd0) bad++;
        end
        chk_eq("reset_outputs", bad, 32'd0);
        reset_n   = 1'b1;
        bus.start = 1'b0;

        run_conv("pos_x", 32'h40000000, 32'h0);
        chk_near("pos_x_mag_c", bus.mag_out, 1073741824.0, 1'b0);
        chk_near("pos_x_ang_c", bus.angle_out, 0.0, 1'b1);

        run_conv("pos_y", 32'h0, 32'h40000000);
        chk_near("pos_y_ang_c", bus.angle_out, 843314856.5, 1'b1);
        chk_vec("pos_y", 32'h0, 32'h40000000);

        run_conv("q1", 32'h2D413CCD, 32'h2D413CCD);
        chk_vec("q1", 32'h2D413CCD, 32'h2D413CCD);
        run_conv("q2", 32'hD2BEC333, 32'h2D413CCD);
        chk_vec("q2", 32'hD2BEC333, 32'h2D413CCD);
        run_conv("q3", 32'hD2BEC333, 32'hD2BEC333);
        chk_vec("q3", 32'hD2BEC333, 32'hD2BEC333);
        run_conv("q4", 32'h2D413CCD, 32'hD2BEC333);
        chk_vec("q4", 32'h2D413CCD, 32'hD2BEC333);

        run_conv("neg_x", 32'hC0000000, 32'h0);
        chk_near("neg_x_ang_c", bus.angle_out, 1686629713.0, 1'b1);
        chk_eq("neg_x_ang_pos", {31'd0, bus.angle_out[31]}, 32'd0);
        run_conv("neg_x_eps", 32'hC0000000, 32'hFFFFFFFF);
        chk_near("neg_x_eps_ang_c", bus.angle_out, -1686629713.0, 1'b1);
        chk_eq("neg_x_eps_ang_neg", {31'd0, bus.angle_out[31]}, 32'd1);

        run_conv("min_val", 32'h80000000, 32'h80000000);
        chk_vec("min_val", 32'h80000000, 32'h80000000);

        run_conv("zero", 32'h0, 32'h0);
        chk_eq("zero_mag", bus.mag_out, 32'd0);

        // start at cycle 5 accepted, at cycle 20 ignored
        ndone = 0;
        at[0] = -1;
        for (int c = 0; c < 80; c++) begin
            bus.x_in  = (c == 20) ? 32'h10000000 : 32'h20000000;
            bus.y_in  = 32'h30000000;
            bus.start = (c == 5 || c == 20);
            @(posedge clock);
            #1;
            if (bus.done) begin
                ndone++;
                at[0] = c;
            end
        end
        bus.start = 1'b0;
        chk_eq("pulse_ndone", ndone, 32'd1);
        chk_eq("pulse_done_at", at[0], 32'd38);
        chk_vec("pulse_res", 32'h20000000, 32'h30000000);

        // start held: one result per 34 cycles, outputs stable between dones
        vx = '{32'h12345678, 32'hE0000000, 32'h05000000, 32'h00000000};
        vy = '{32'hF1000000, 32'h33000000, 32'hA0000000, 32'h00000000};
        ndone    = 0;
        unstable = 0;
        at       = '{-1, -1, -1};
        pm       = bus.mag_out;
        pa       = bus.angle_out;
        bus.x_in  = vx[0];
        bus.y_in  = vy[0];
        bus.start = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(posedge clock);
            #1;
            if (bus.done) begin
                if (ndone < 3) begin
                    at[ndone] = c;
                    chk_vec($sformatf("held%0d", ndone), vx[ndone], vy[ndone]);
                end
                ndone++;
                pm = bus.mag_out;
                pa = bus.angle_out;
                if (ndone >= 3) bus.start = 1'b0;
                else begin
                    bus.x_in = vx[ndone];
                    bus.y_in = vy[ndone];
                end
            end else if (bus.mag_out !== pm || bus.angle_out !== pa) begin
                unstable++;
            end
        end
        bus.start = 1'b0;
        chk_eq("held_ndone", ndone, 32'd3);
        chk_eq("held_first", at[0], 32'd33);
        chk_eq("held_gap1", at[1] - at[0], 32'd34);
        chk_eq("held_gap2", at[2] - at[1], 32'd34);
        chk_eq("held_stable", unstable, 32'd0);

        // reset during iteration 10 aborts the job
        bus.x_in  = 32'h30000000;
        bus.y_in  = 32'h10000000;
        bus.start = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        chk_eq("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk_eq("mid_rst_mag", bus.mag_out, 32'd0);
        chk_eq("mid_rst_ang", bus.angle_out, 32'd0);
        reset_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (bus.done) ndone++;
        end
        chk_eq("mid_rst_nodone", ndone, 32'd0);
        run_conv("after_rst", 32'h30000000, 32'h10000000);
        chk_vec("after_rst", 32'h30000000, 32'h10000000);

        // random vectors with radius >= 0.25
        for (int k = 0; k < 16; k++) begin
            do begin
                rx = $urandom;
                ry = $urandom;
            end while (ref_mag(rx, ry) < 0.25 * Q30);
            run_conv($sformatf("rnd%0d", k), rx, ry);
            chk_vec($sformatf("rnd%0d", k), rx, ry);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
